// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount bit-manipulation group.
package popcount_pkg;

    localparam int unsigned MAX_W  = 16;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } popcount_enum_state_t;

    // Number of set bits in a word of up to MAX_W bits.
    function automatic logic [CNT_W-1:0] popcount_f(input logic [MAX_W-1:0] w);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            cnt = cnt + CNT_W'(w[i]);
        end
        return cnt;
    endfunction

    // Count of trailing zeros; an all-zero word yields MAX_W.
    function automatic logic [CNT_W-1:0] ctz_f(input logic [MAX_W-1:0] w);
        logic [CNT_W-1:0] tz;
        tz = CNT_W'(MAX_W);
        for (int i = int'(MAX_W) - 1; i >= 0; i--) begin
            if (w[i]) begin
                tz = CNT_W'(i);
            end
        end
        return tz;
    endfunction

endpackage

// File: rtl/gosper_next.sv
// Gosper's step: next larger word with the same popcount (no divider).
module gosper_next
    import popcount_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] w_in,
    output logic [W-1:0] w_out
);

    logic [W-1:0]       low_bit;
    logic [W-1:0]       ripple;
    logic [W-1:0]       moved;
    logic [CNT_W-1:0]   tz;

    // Carry the lowest run up one place, then refill the low ones right-aligned.
    always_comb begin
        low_bit = w_in & (~w_in + W'(1));
        ripple  = w_in + low_bit;
        tz      = ctz_f(MAX_W'(w_in));
        moved   = (ripple ^ w_in) >> 2;
        w_out   = (moved >> tz) | ripple;
    end

endmodule

// File: rtl/popcount_enum.sv
// Streaming enumerator of all W-bit words with popcount k, ascending.
// Optional self-checker enabled by macro POPCOUNT_ENUM_SELFCHECK_EN.
module popcount_enum
    import popcount_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  word,
    output logic          last,
    output logic [W-1:0]  index,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned WP1 = W + 1;

    popcount_enum_state_t state_q, state_d;
    logic [W-1:0]         word_q, word_d;
    logic [W-1:0]         index_q, index_d;
    logic [W-1:0]         last_word_q, last_word_d;
    logic [W-1:0]         next_word_c;
    logic [W-1:0]         first_word_c;
    logic                 last_c;
    logic                 k_in_range_c;

    gosper_next #(.W(W)) u_gosper (
        .w_in  (word_q),
        .w_out (next_word_c)
    );

    // First word (k low ones) and range check for the incoming k.
    always_comb begin
        first_word_c = W'((WP1'(1) << k) - WP1'(1));
        k_in_range_c = (32'(k) <= W);
    end

    // Final word of the run is the k ones packed at the top.
    assign last_c    = (state_q == EMIT) && (word_q == last_word_q);

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign word      = word_q;
    assign index     = index_q;
    assign last      = last_c;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        index_d     = index_q;
        last_word_d = last_word_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_in_range_c) begin
                        word_d      = first_word_c;
                        index_d     = '0;
                        last_word_d = W'(first_word_c << (W - 32'(k)));
                        state_d     = EMIT;
                    end else begin
                        state_d     = FINISH;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_c) begin
                        state_d = FINISH;
                    end else begin
                        word_d  = next_word_c;
                        index_d = index_q + W'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            index_q     <= '0;
            last_word_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            index_q     <= index_d;
            last_word_q <= last_word_d;
        end
    end

`ifdef POPCOUNT_ENUM_SELFCHECK_EN
    logic [CW-1:0] k_q, k_d;
    logic [W-1:0]  prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic          err_q, err_d;

    // Check each accepted word for popcount and strict ascending order.
    always_comb begin
        k_d         = k_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        err_d       = err_q;
        if ((state_q == IDLE) && start) begin
            k_d         = k;
            have_prev_d = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (popcount_f(MAX_W'(word_q)) != CNT_W'(k_q)) begin
                err_d = 1'b1;
            end
            if (have_prev_q && (word_q <= prev_q)) begin
                err_d = 1'b1;
            end
            prev_d      = word_q;
            have_prev_d = 1'b1;
        end
    end

    // Checker registers; err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q         <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            k_q         <= k_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_enum.sv
// Directed testbench for popcount_enum (W=8).
module tb_popcount_enum;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] k;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  word;
    logic          last;
    logic [W-1:0]  index;
    logic          busy;
    logic          done;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] got_q[$];
    int           last_idx;
    int           cycles;
    int           bad_pc;

    popcount_enum #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word      (word),
        .last      (last),
        .index     (index),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int kv);
        start = 1'b1;
        k     = CW'(kv);
        step();
        start = 1'b0;
    endtask

    // Gather words until the last handshake, then check the done pulse and return to idle.
    task automatic collect(input string tag, input int budget);
        bit fin;
        fin      = 1'b0;
        got_q.delete();
        last_idx = -1;
        cycles   = 0;
        bad_pc   = 0;
        while (!fin && cycles < budget) begin
            if (out_valid && out_ready) begin
                got_q.push_back(word);
                if ($countones(word) != int'(k)) bad_pc++;
                if (last) begin
                    last_idx = int'(index);
                    fin      = 1'b1;
                end
            end
            step();
            cycles++;
        end
        check_eq({tag, "_finished"}, 32'(fin), 32'd1);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd1);
        check_eq({tag, "_valid_after"}, 32'(out_valid), 32'd0);
        step();
        check_eq({tag, "_done_clear"}, 32'(done), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k         = '0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_word",  32'(word),      32'd0);
        check_eq("rst_index", 32'(index),     32'd0);
        check_eq("rst_last",  32'(last),      32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_done",  32'(done),      32'd0);
        check_eq("rst_err",   32'(err),       32'd0);
        rst = 1'b0;
        step();

        // k=3: 56 words, one per cycle
        start_run(3);
        check_eq("k3_busy", 32'(busy), 32'd1);
        collect("k3", 200);
        check_eq("k3_count",  32'(got_q.size()), 32'd56);
        check_eq("k3_cycles", 32'(cycles),       32'd56);
        if (got_q.size() >= 3) begin
            check_eq("k3_w0", 32'(got_q[0]), 32'h07);
            check_eq("k3_w1", 32'(got_q[1]), 32'h0B);
            check_eq("k3_w2", 32'(got_q[2]), 32'h0D);
            check_eq("k3_wlast", 32'(got_q[got_q.size()-1]), 32'hE0);
        end
        check_eq("k3_last_idx", 32'(last_idx), 32'd55);
        check_eq("k3_popcount", 32'(bad_pc),   32'd0);
        check_eq("k3_err",      32'(err),      32'd0);

        // k=0: single zero word
        start_run(0);
        check_eq("k0_word", 32'(word), 32'h00);
        check_eq("k0_last", 32'(last), 32'd1);
        collect("k0", 10);
        check_eq("k0_count",    32'(got_q.size()), 32'd1);
        check_eq("k0_last_idx", 32'(last_idx),     32'd0);

        // k=8: single all-ones word
        start_run(8);
        check_eq("k8_word", 32'(word), 32'hFF);
        check_eq("k8_last", 32'(last), 32'd1);
        collect("k8", 10);
        check_eq("k8_count", 32'(got_q.size()), 32'd1);

        // k=9: out of range, straight to done
        start_run(9);
        check_eq("k9_valid", 32'(out_valid), 32'd0);
        check_eq("k9_done",  32'(done),      32'd1);
        step();
        check_eq("k9_valid2", 32'(out_valid), 32'd0);
        check_eq("k9_done2",  32'(done),      32'd0);
        check_eq("k9_idle",   32'(busy),      32'd0);

        // k=2 with backpressure and an ignored mid-run start
        start_run(2);
        check_eq("k2_w0", 32'(word), 32'h03);
        step();
        check_eq("k2_w1", 32'(word), 32'h05);
        out_ready = 1'b0;
        start     = 1'b1;
        k         = CW'(5);
        for (int i = 0; i < 3; i++) begin
            step();
            start = 1'b0;
            check_eq("k2_hold_word",  32'(word),      32'h05);
            check_eq("k2_hold_index", 32'(index),     32'd1);
            check_eq("k2_hold_valid", 32'(out_valid), 32'd1);
        end
        k         = CW'(2);
        out_ready = 1'b1;
        step();
        check_eq("k2_after_stall", 32'(word),  32'h06);
        check_eq("k2_after_index", 32'(index), 32'd2);
        collect("k2", 100);
        check_eq("k2_rest_count", 32'(got_q.size()), 32'd26);
        check_eq("k2_last_idx",   32'(last_idx),     32'd27);
        check_eq("k2_popcount",   32'(bad_pc),       32'd0);
        check_eq("k2_err",        32'(err),          32'd0);

        // k=4 with reset mid-run at word 10
        start_run(4);
        cycles = 0;
        while (int'(index) != 10 && cycles < 50) begin
            step();
            cycles++;
        end
        check_eq("k4_reach10", 32'(index), 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("k4_rst_valid", 32'(out_valid), 32'd0);
        check_eq("k4_rst_busy",  32'(busy),      32'd0);
        check_eq("k4_rst_word",  32'(word),      32'd0);
        check_eq("k4_rst_done",  32'(done),      32'd0);
        step();
        check_eq("k4_rst_done2", 32'(done), 32'd0);

        // k=1 fresh run after reset
        start_run(1);
        collect("k1", 20);
        check_eq("k1_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            check_eq("k1_word", 32'(got_q[i]), 32'd1 << i);
        end
        check_eq("k1_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_enum.md
# popcount_enum

Streaming enumerator that is the inverse of the population-count block: given a target count `k`, it emits, one per handshake, every `W`-bit word whose popcount equals `k`. Words come out in ascending numeric order, using Gosper's next-combination step. It sits beside `popcount` in the bit-manipulation group and drives stimulus generators and exhaustive checkers downstream.

## Interface
- `W`, default 8: word width, 2..16.
- `CW`, default `$clog2(W+1)`: width of `k`.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: request enumeration; sampled only in IDLE.
- `k  in  CW`: target popcount; sampled with `start`.
- `out_valid  out  1`: `word` is valid.
- `out_ready  in  1`: consumer accepts `word`.
- `word  out  W`: current combination.
- `last  out  1`: `word` is the final combination; qualified by `out_valid`.
- `index  out  W`: 0-based ordinal of `word` within the run.
- `busy  out  1`: enumerator is not in IDLE.
- `done  out  1`: one-cycle pulse at end of run.
- `err  out  1`: sticky self-check failure flag.

## Operation
- States:
  - IDLE: `busy=0`, `out_valid=0`.
  - EMIT: `out_valid=1`.
  - FINISH: `done=1`.
- IDLE + `start`:
  - `k<=W`: `word<=(1<<k)-1`, `index<=0`, go to EMIT.
  - `k>W`: go straight to FINISH; no word is emitted.
- EMIT, handshake (`out_valid && out_ready`):
  - `last=1`: go to FINISH.
  - otherwise: `word<=gosper_next(word)`, `index<=index+1`.
- `gosper_next(w)`:
  - `c=w&-w`; `r=w+c`.
  - `next=(((r^w)>>2)>>ctz(w))|r`.
  - No divider; width-`W` arithmetic, carry-out discarded.
- `last` is combinational: `word == ((1<<k)-1)<<(W-k)`, using the latched `k`.
  - `k=0` gives word 0, the only and last word.
  - `k=W` gives all ones, the only and last word.
- FINISH: `done=1` for exactly one cycle, then IDLE unconditionally.
- `start` outside IDLE is ignored. A new `k` is not sampled mid-run.
- Total words per run = C(W,k). `index` never wraps, since C(W,k) < 2^W.

## Timing
- Reset values:
  - state IDLE
  - `out_valid=0`, `word=0`, `index=0`, `last=0`
  - `busy=0`, `done=0`, `err=0`
- `start` sampled at edge t: `out_valid=1` and the first word are visible after edge t; `busy=1` from the same edge.
- Throughput: one word per cycle while `out_ready=1`.
- Backpressure: with `out_valid=1 && out_ready=0`, `word`, `index` and `last` hold stable.
- Final handshake at edge t: FINISH after t with `done=1`, `out_valid=0`; IDLE after t+1.
- `k>W`, `start` at edge t: `done=1` after t, with no `out_valid` at any point.
- `rst` mid-run: all outputs return to their reset values at the next edge. Any word in flight is dropped, and no `done` pulse is produced.
- `rst` has priority over `start` on the same edge.

## Configuration
- Macro `POPCOUNT_ENUM_SELFCHECK_EN`.
- Defined:
  - Every handshaked word is checked against the package popcount function with the latched `k`.
  - Words are also checked for strict monotonic increase against the previous word.
  - Any mismatch sets `err`; it clears only on `rst`.
- Undefined:
  - `err` is tied to 0.
  - No checker logic is synthesized.

## Structure
- Package `popcount_pkg`:
  - `popcount_enum_state_t` (IDLE, EMIT, FINISH).
  - Functions `popcount_f(w)` and `ctz_f(w)`.
- Sub-module `gosper_next`: purely combinational, parameter `W`, one input word, one output word.
- Top module owns the FSM, registers and optional checker.

## Test plan
- `W=8`, `k=3`, `out_ready=1`:
  - Exactly 56 words, one per cycle.
  - First three words are 0x07, 0x0B, 0x0D.
  - Final word is 0xE0 with `last=1` and `index=55`.
  - `done` pulses one cycle later; `err=0`.
- `k=0` -> single word 0x00 with `last=1`, `index=0`, then `done`.
- `k=8` -> single word 0xFF with `last=1`, then `done`.
- `k=9` -> `out_valid` never asserts; `done` pulses the cycle after `start`.
- `k=2`, drop `out_ready` for 3 cycles while `word=0x05`:
  - `word` and `index` stay 0x05 and 1 throughout.
  - The next accepted word is 0x06.
  - `start` pulsed mid-run with `k=5` is ignored: still 28 words total.
- `k=4`, assert `rst` at word 10:
  - Next cycle `out_valid=0`, `busy=0`, `word=0`, and no `done` pulse.
  - A fresh run with `k=1` then yields 0x01, 0x02, …, 0x80.
